// File: rtl/pixel_addr_gen_pkg.sv
// pixel_addr_pkg: shared definitions for the pixel address generator.
//   state_t        : walk FSM states (IDLE/RUN/DRAIN/DONE)
//   DEF_*BITS      : default widths used by pixel_addr_gen and its interface
//   DEFAULT_STRIDE : row pitch of the original fixed 640-wide frame (+1 guard)
package pixel_addr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_XBITS     = 10;
  localparam int DEF_YBITS     = 10;
  localparam int DEF_PIXELBITS = 6;
  localparam int DEF_ADDRBITS  = 32;

  localparam int DEFAULT_STRIDE = 641;

endpackage

// File: rtl/pixel_addr_gen_if.sv
// pixel_addr_gen_if: address output channel (valid/ready) from the generator
// to the SDRAM write master.
//   addr       : byte address
//   addr_x/y   : pixel coordinate belonging to addr
//   addr_valid : addr/addr_x/addr_y are valid
//   addr_ready : consumer accepts the current output
// master = generator side, slave = consumer side.
interface pixel_addr_gen_if #(
  parameter int XBITS    = 10,
  parameter int YBITS    = 10,
  parameter int ADDRBITS = 32
) ();

  logic [ADDRBITS-1:0] addr;
  logic [XBITS-1:0]    addr_x;
  logic [YBITS-1:0]    addr_y;
  logic                addr_valid;
  logic                addr_ready;

  modport master (
    output addr, addr_x, addr_y, addr_valid,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_x, addr_y, addr_valid,
    output addr_ready
  );

endinterface

// File: rtl/pixel_addr_gen_pipe.sv
// addr_pipe: two-stage multiply-add pipeline for pixel addresses.
//   stage 1: lin  = y * stride + x          (full width XBITS+YBITS+2)
//   stage 2: addr = offset + pixel_size*lin (modulo 2^ADDRBITS)
// The x/y coordinate travels alongside the arithmetic. Both stages share one
// enable; when en is low every register holds, which keeps the outputs stable
// while the consumer stalls.
// Ports:
//   clk, rst (sync, active-high), en (advance), in_valid/in_x/in_y (issued
//   coordinate), stride/pixel_size/offset (latched walk configuration),
//   s1_valid (stage 1 occupied), out_valid/out_addr/out_x/out_y (stage 2).
module addr_pipe #(
  parameter int XBITS     = 10,
  parameter int YBITS     = 10,
  parameter int PIXELBITS = 6,
  parameter int ADDRBITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [XBITS-1:0]     in_x,
  input  logic [YBITS-1:0]     in_y,
  input  logic [XBITS:0]       stride,
  input  logic [PIXELBITS-1:0] pixel_size,
  input  logic [ADDRBITS-1:0]  offset,
  output logic                 s1_valid,
  output logic                 out_valid,
  output logic [ADDRBITS-1:0]  out_addr,
  output logic [XBITS-1:0]     out_x,
  output logic [YBITS-1:0]     out_y
);

  localparam int LINBITS = XBITS + YBITS + 2;

  logic [LINBITS-1:0]  lin_d;
  logic [LINBITS-1:0]  s1_lin;
  logic [XBITS-1:0]    s1_x;
  logic [YBITS-1:0]    s1_y;
  logic [ADDRBITS-1:0] addr_d;

  always_comb begin
    lin_d  = LINBITS'(in_y) * LINBITS'(stride) + LINBITS'(in_x);
    // Truncation of lin (if ever wider than the address) does not change the
    // result modulo 2^ADDRBITS.
    addr_d = offset + ADDRBITS'(pixel_size) * ADDRBITS'(s1_lin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lin    <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_x     <= '0;
      out_y     <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_lin    <= lin_d;
      s1_x      <= in_x;
      s1_y      <= in_y;
      out_valid <= s1_valid;
      out_addr  <= addr_d;
      out_x     <= s1_x;
      out_y     <= s1_y;
    end
  end

endmodule

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: walks a rectangular pixel region in raster order and emits
// offset + pixel_size * (y * stride + x) per pixel over a valid/ready channel.
// Ports:
//   clk, rst (sync, active-high)
//   start + x_start/x_end/y_start/y_end/stride/pixel_size/offset: walk request
//     and configuration, latched when start is accepted in IDLE
//   addr_if (master): addr, addr_x, addr_y, addr_valid out; addr_ready in
//   busy: walk in progress; done: end-of-walk pulse; err: rejection pulse
// Build option: define PIXEL_ADDR_GEN_BOUNDS_CHECK_EN to reject regions with
// x_end < x_start, y_end < y_start, x_end >= stride or pixel_size == 0.
// Without it err is constant 0.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one coordinate per non-stalled cycle
// DRAIN | last coordinate issued, waiting for the pipeline to empty
// DONE  | done pulse high for one cycle, busy drops on exit
module pixel_addr_gen
  import pixel_addr_pkg::*;
#(
  parameter int XBITS     = DEF_XBITS,
  parameter int YBITS     = DEF_YBITS,
  parameter int PIXELBITS = DEF_PIXELBITS,
  parameter int ADDRBITS  = DEF_ADDRBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [XBITS-1:0]     x_start,
  input  logic [XBITS-1:0]     x_end,
  input  logic [YBITS-1:0]     y_start,
  input  logic [YBITS-1:0]     y_end,
  input  logic [XBITS:0]       stride,
  input  logic [PIXELBITS-1:0] pixel_size,
  input  logic [ADDRBITS-1:0]  offset,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  pixel_addr_gen_if.master     addr_if
);

  state_t               state;
  logic [XBITS-1:0]     x_start_q, x_end_q, x_cnt;
  logic [YBITS-1:0]     y_end_q, y_cnt;
  logic [XBITS:0]       stride_q;
  logic [PIXELBITS-1:0] pixel_size_q;
  logic [ADDRBITS-1:0]  offset_q;
  logic                 stall;
  logic                 issue;
  logic                 s1_valid;
  logic                 reject;

  // The pipeline and the counter freeze together while an output waits.
  assign stall = addr_if.addr_valid & ~addr_if.addr_ready;
  assign issue = (state == RUN) & ~stall;

`ifdef PIXEL_ADDR_GEN_BOUNDS_CHECK_EN
  assign reject = (x_end < x_start) | (y_end < y_start) |
                  ({1'b0, x_end} >= stride) | (pixel_size == '0);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      x_start_q    <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      stride_q     <= '0;
      pixel_size_q <= '0;
      offset_q     <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_start_q    <= x_start;
            x_end_q      <= x_end;
            y_end_q      <= y_end;
            stride_q     <= stride;
            pixel_size_q <= pixel_size;
            offset_q     <= offset;
            if (reject) begin
              err <= 1'b1;
            end else begin
              x_cnt <= x_start;
              y_cnt <= y_start;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (x_cnt == x_end_q) begin
              x_cnt <= x_start_q;
              if (y_cnt == y_end_q) state <= DRAIN;
              else                  y_cnt <= y_cnt + YBITS'(1);
            end else begin
              x_cnt <= x_cnt + XBITS'(1);
            end
          end
        end
        DRAIN: begin
          // Empty pipe means the final address has already handshaken.
          if (!s1_valid && !addr_if.addr_valid) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  addr_pipe #(
    .XBITS     (XBITS),
    .YBITS     (YBITS),
    .PIXELBITS (PIXELBITS),
    .ADDRBITS  (ADDRBITS)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .en         (~stall),
    .in_valid   (issue),
    .in_x       (x_cnt),
    .in_y       (y_cnt),
    .stride     (stride_q),
    .pixel_size (pixel_size_q),
    .offset     (offset_q),
    .s1_valid   (s1_valid),
    .out_valid  (addr_if.addr_valid),
    .out_addr   (addr_if.addr),
    .out_x      (addr_if.addr_x),
    .out_y      (addr_if.addr_y)
  );

endmodule

// File: tb/tb_pixel_addr_gen.sv
// tb_pixel_addr_gen: directed self-checking bench for pixel_addr_gen.
// Inputs are driven and outputs sampled on the falling edge; "cycle k" below
// means the falling edge after the k-th rising edge following the edge that
// sampled start (k = 0 is that sampling edge).
module tb_pixel_addr_gen;
  import pixel_addr_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  x_start, x_end, y_start, y_end;
  logic [10:0] stride;
  logic [5:0]  pixel_size;
  logic [31:0] offset;
  logic        busy, done, err;

  int checks = 0;
  int passed = 0;

  pixel_addr_gen_if bus ();

  pixel_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x_start    (x_start),
    .x_end      (x_end),
    .y_start    (y_start),
    .y_end      (y_end),
    .stride     (stride),
    .pixel_size (pixel_size),
    .offset     (offset),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .addr_if    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_walk(input logic [9:0] xs, input logic [9:0] xe,
                            input logic [9:0] ys, input logic [9:0] ye,
                            input logic [10:0] st, input logic [5:0] ps,
                            input logic [31:0] off);
    @(negedge clk);
    x_start = xs; x_end = xe; y_start = ys; y_end = ye;
    stride = st; pixel_size = ps; offset = off;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bus.addr_ready = 1'b1;
    x_start = '0; x_end = '0; y_start = '0; y_end = '0;
    stride = '0; pixel_size = '0; offset = '0;
    gap(3);
    checks++; if (bus.addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.addr); else passed++;
    checks++; if (bus.addr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.addr_valid); else passed++;
    checks++; if ({bus.addr_x, bus.addr_y} !== 20'h0) $display("FAIL reset_xy: got %h want 0", {bus.addr_x, bus.addr_y}); else passed++;
    checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, err}); else passed++;
    rst = 1'b0;
    gap(1);
  endtask

  // Two pixels, no stall: addresses on cycles 2 and 3, done on cycle 5.
  task automatic test_basic;
    logic        exp_v;
    logic [31:0] exp_a;
    start_walk(10'd0, 10'd1, 10'd0, 10'd0, 11'(DEFAULT_STRIDE), 6'd3, 32'h1000);
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy); else passed++;
    checks++; if (bus.addr_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.addr_valid); else passed++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_v = (k == 2 || k == 3);
      checks++; if (bus.addr_valid !== exp_v) $display("FAIL basic_valid c%0d: got %b want %b", k, bus.addr_valid, exp_v); else passed++;
      if (exp_v) begin
        exp_a = (k == 2) ? 32'h1000 : 32'h1003;
        checks++; if (bus.addr !== exp_a) $display("FAIL basic_addr c%0d: got %h want %h", k, bus.addr, exp_a); else passed++;
        checks++; if (bus.addr_x !== 10'(k - 2)) $display("FAIL basic_x c%0d: got %0d want %0d", k, bus.addr_x, k - 2); else passed++;
      end
      checks++; if (done !== (k == 5)) $display("FAIL basic_done c%0d: got %b want %b", k, done, (k == 5)); else passed++;
      checks++; if (busy !== (k <= 5)) $display("FAIL basic_busy c%0d: got %b want %b", k, busy, (k <= 5)); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL basic_err c%0d: got %b want 0", k, err); else passed++;
    end
    gap(1);
  endtask

  task automatic test_single;
    start_walk(10'd5, 10'd5, 10'd2, 10'd2, 11'd641, 6'd3, 32'h1000);
    gap(2);
    checks++; if (bus.addr_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.addr_valid); else passed++;
    checks++; if (bus.addr !== 32'h1F15) $display("FAIL single_addr: got %h want 00001f15", bus.addr); else passed++;
    checks++; if (bus.addr_x !== 10'd5 || bus.addr_y !== 10'd2) $display("FAIL single_xy: got (%0d,%0d) want (5,2)", bus.addr_x, bus.addr_y); else passed++;
    gap(1);
    checks++; if (bus.addr_valid !== 1'b0) $display("FAIL single_extra: got valid %b want 0", bus.addr_valid); else passed++;
    gap(1);
    checks++; if (done !== 1'b1) $display("FAIL single_done_c4: got %b want 1", done); else passed++;
    gap(2);
  endtask

  // 2x2 region, stride 4, consumer stalls for three cycles after the first transfer.
  task automatic test_stall;
    logic [31:0] exp_a [4];
    logic [9:0]  exp_x [4];
    logic [9:0]  exp_y [4];
    int          idx;
    int          dones;
    exp_a = '{32'd0, 32'd1, 32'd4, 32'd5};
    exp_x = '{10'd0, 10'd1, 10'd0, 10'd1};
    exp_y = '{10'd0, 10'd0, 10'd1, 10'd1};
    idx = 0; dones = 0;
    start_walk(10'd0, 10'd1, 10'd0, 10'd1, 11'd4, 6'd1, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.addr_ready = !(k >= 3 && k <= 5);
      if (done) dones++;
      if (bus.addr_valid) begin
        if (idx >= 4) begin
          checks++; $display("FAIL stall_extra c%0d: got addr %h want no output", k, bus.addr);
        end else begin
          checks++; if (bus.addr !== exp_a[idx]) $display("FAIL stall_addr c%0d: got %h want %h", k, bus.addr, exp_a[idx]); else passed++;
          checks++; if (bus.addr_x !== exp_x[idx] || bus.addr_y !== exp_y[idx]) $display("FAIL stall_xy c%0d: got (%0d,%0d) want (%0d,%0d)", k, bus.addr_x, bus.addr_y, exp_x[idx], exp_y[idx]); else passed++;
          if (bus.addr_ready) idx++;
        end
      end
    end
    bus.addr_ready = 1'b1;
    checks++; if (idx !== 4) $display("FAIL stall_count: got %0d want 4", idx); else passed++;
    checks++; if (dones !== 1) $display("FAIL stall_done: got %0d pulses want 1", dones); else passed++;
  endtask

  task automatic test_wrap;
    start_walk(10'd1, 10'd1, 10'd0, 10'd0, 11'd641, 6'd1, 32'hFFFF_FFFF);
    gap(2);
    checks++; if (bus.addr_valid !== 1'b1 || bus.addr !== 32'h0) $display("FAIL wrap_addr: got v=%b %h want v=1 00000000", bus.addr_valid, bus.addr); else passed++;
    gap(4);
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    start_walk(10'd0, 10'd9, 10'd0, 10'd0, 11'd641, 6'd1, 32'h40);
    gap(4);
    rst = 1'b1;
    gap(1);
    checks++; if (bus.addr_valid !== 1'b0 || bus.addr !== 32'h0) $display("FAIL rstmid_out: got v=%b %h want v=0 0", bus.addr_valid, bus.addr); else passed++;
    checks++; if ({bus.addr_x, bus.addr_y} !== 20'h0) $display("FAIL rstmid_xy: got %h want 0", {bus.addr_x, bus.addr_y}); else passed++;
    checks++; if ({busy, done, err} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {busy, done, err}); else passed++;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || bus.addr_valid) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL rstmid_stale: got %0d active cycles want 0", dones); else passed++;
    // lin = 1*641 + 3 = 644; 0x100 + 2*644 = 0x608
    start_walk(10'd3, 10'd3, 10'd1, 10'd1, 11'd641, 6'd2, 32'h100);
    gap(2);
    checks++; if (bus.addr_valid !== 1'b1 || bus.addr !== 32'h608) $display("FAIL rstmid_restart: got v=%b %h want v=1 00000608", bus.addr_valid, bus.addr); else passed++;
    gap(2);
    checks++; if (done !== 1'b1) $display("FAIL rstmid_restart_done: got %b want 1", done); else passed++;
    gap(2);
  endtask

  task automatic test_bounds;
    int bad;
    bad = 0;
`ifdef PIXEL_ADDR_GEN_BOUNDS_CHECK_EN
    start_walk(10'd0, 10'd700, 10'd0, 10'd0, 11'd641, 6'd1, 32'h0);
    checks++; if (err !== 1'b1) $display("FAIL bounds_err: got %b want 1", err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL bounds_busy0: got %b want 0", busy); else passed++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (err || busy || bus.addr_valid || done) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL bounds_quiet: got %0d active cycles want 0", bad); else passed++;
`else
    // No checking: pixel_size 0 is accepted and yields the bare offset.
    start_walk(10'd0, 10'd0, 10'd0, 10'd0, 11'd4, 6'd0, 32'h55);
    checks++; if (err !== 1'b0) $display("FAIL nocheck_err: got %b want 0", err); else passed++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (err) bad++;
      if (k == 2) begin
        checks++; if (bus.addr_valid !== 1'b1 || bus.addr !== 32'h55) $display("FAIL nocheck_addr: got v=%b %h want v=1 00000055", bus.addr_valid, bus.addr); else passed++;
      end
    end
    checks++; if (bad !== 0) $display("FAIL nocheck_err_late: got %0d err cycles want 0", bad); else passed++;
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_single;
    test_stall;
    gap(2);
    test_wrap;
    test_reset_mid;
    test_bounds;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pixel_addr_gen.md
# pixel_addr_gen

Sequential pixel-address generator for the Julia worker. It walks a rectangular pixel region in raster order and computes `offset + pixel_size * (y * stride + x)` for each pixel through a two-stage pipeline. Each SDRAM byte address is delivered over a valid/ready handshake. It sits between the worker's pixel iterator and the SDRAM write master. It generalises the fixed-width, fixed-641-stride address calculator with runtime stride, parametrised widths, region walking and backpressure.

## Interface
- `XBITS`, 10, width of x coordinates.
- `YBITS`, 10, width of y coordinates.
- `PIXELBITS`, 6, width of `pixel_size`.
- `ADDRBITS`, 32, width of `offset` and `addr`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a region walk; sampled only in IDLE.
- `x_start`, `x_end` in XBITS: inclusive x bounds; latched on accepted `start`.
- `y_start`, `y_end` in YBITS: inclusive y bounds; latched on accepted `start`.
- `stride` in XBITS+1: row pitch in pixels; latched on accepted `start`.
- `pixel_size` in PIXELBITS: bytes per pixel; latched on accepted `start`.
- `offset` in ADDRBITS: frame base address; latched on accepted `start`.
- `addr` out ADDRBITS: computed byte address.
- `addr_x` out XBITS: coordinate belonging to `addr`.
- `addr_y` out YBITS: coordinate belonging to `addr`.
- `addr_valid` out 1: `addr`, `addr_x` and `addr_y` are valid.
- `addr_ready` in 1: consumer accepts the output.
- `busy` out 1: a walk is in progress.
- `done` out 1: one-cycle pulse at the end of a walk.
- `err` out 1: one-cycle pulse on region rejection (bounds check only).

## Operation
- FSM states and transitions:
  - IDLE: on `start`, latch the configuration, load the coordinate counter with (`x_start`, `y_start`), and go to RUN (or reject; see Configuration).
  - RUN: issue one coordinate per non-stalled cycle. Order is x increments first; at `x == x_end`, x reloads `x_start` and y increments. After issuing (`x_end`, `y_end`), go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the last output has handshaken, then go to DONE.
  - DONE: pulse `done` for one cycle, then go to IDLE.
- A transfer occurs on each cycle with `addr_valid && addr_ready`.
- Stall: when `addr_valid && !addr_ready`, the counter and both pipe stages hold. `addr`, `addr_x` and `addr_y` must stay stable.
- `start` is ignored while `busy` is high.
- Arithmetic:
  - Stage 1: `lin = y * stride + x`, kept at full width XBITS+YBITS+2.
  - Stage 2: `addr = offset + pixel_size * lin`, truncated modulo 2^ADDRBITS. Wrap-around is legal and silent.
- Counter end tests are equality-based. A region with `x_end < x_start` (bounds check disabled) wraps through 2^XBITS; it is deterministic but unsupported.
- `rst` at any point:
  - state returns to IDLE and the pipeline is flushed;
  - every output goes to 0;
  - any in-flight address is discarded and no `done` is produced.

## Timing
- Reset value of all outputs is 0.
- Latency: `addr_valid` first rises 2 edges after the edge that samples `start`.
- Throughput is 1 address/cycle while `addr_ready` is held high.
- `busy` rises the edge after `start` and falls together with the `done` pulse.
- `done` asserts the cycle after the final handshake.
- A region of N pixels with no stalls takes N+3 cycles from `start` to `done`.

## Configuration
- Macro: `PIXEL_ADDR_GEN_BOUNDS_CHECK_EN`.
- With the macro defined, an accepted `start` is checked against the latched configuration. It is rejected if any of these hold:
  - `x_end < x_start`;
  - `y_end < y_start`;
  - `x_end >= stride`;
  - `pixel_size == 0`.
- On rejection: `err` pulses for one cycle, no addresses are issued, no `done` is produced, and `busy` stays low. The FSM remains in IDLE.
- Without the macro: `err` is tied to 0 and no checks are made.

## Structure
- Package `pixel_addr_pkg` holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - default width constants;
  - the `DEFAULT_STRIDE = 641` constant.
- Sub-module `addr_pipe`: two-stage multiply-add pipeline with a shared stall enable, carrying x/y alongside. The top level holds the FSM and the coordinate counter.

## Test plan
- stride=641, pixel_size=3, offset=0x1000, region (0,0)-(1,0), `addr_ready`=1 → addresses 0x1000 then 0x1003. `done` pulses at cycle 5 after `start`.
- Single pixel (5,2), stride=641, pixel_size=3, offset=0x1000 → one address 0x1F15, `addr_x`=5, `addr_y`=2.
- Region (0,0)-(1,1), stride=4, pixel_size=1, offset=0, `addr_ready` low for 3 cycles mid-walk → sequence 0,1,4,5 with no loss or duplicate; outputs stable during the stall.
- offset=0xFFFFFFFF, pixel_size=1, pixel (1,0) → `addr` = 0x00000000.
- Assert `rst` during RUN after 2 transfers → all outputs 0 next cycle. A new `start` is then accepted normally.
- With `PIXEL_ADDR_GEN_BOUNDS_CHECK_EN`: `x_end`=700, stride=641 → `err` one cycle, `addr_valid` never rises, `busy` stays 0.
